dl_mac_result_collector: RTL

//   Downstream stage of the DLFloat16 MAC. Captures each registered MAC result
//   (c_out, exception_flags) when in_valid is high and buffers it in a FIFO.

---
 rtl/dl_mac_result_collector.sv | 94 +++++++++
 1 files changed

// File: rtl/dl_mac_result_collector.sv
// Result collector behind the DLFloat16 MAC: buffers each valid result in a
// show-ahead FIFO and tracks sticky exception status, drops and an accepted-beat count.
module dl_mac_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [19:0]              in_result,
    input  logic [4:0]               in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [4:0]               out_flags,
    output logic [4:0]               sticky_flags,
    input  logic                     sticky_clr,
    output logic                     drop_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         result_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [20:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          drop;
    logic [4:0]    cap_flags;

    // Nonzero overflow bits above the 16-bit value mean the result was rounded: fold into inexact.
    function automatic logic [4:0] capture_flags(input logic [4:0] flags, input logic [3:0] upper);
        return {flags[4], flags[3] | (|upper), flags[2:0]};
    endfunction

    always_comb begin
        full      = (level == FULL_LVL);
        out_valid = (level != '0);
        pop       = out_valid & out_ready;
        push      = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
        cap_flags = capture_flags(in_flags, in_result[19:16]);
        {out_flags, out_data} = mem[rd_ptr];
    end

    // Storage is data only, left unreset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cap_flags, in_result[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sticky_flags <= '0;
            drop_err     <= 1'b0;
            result_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);

            // A beat arriving with the clear survives it.
            if (sticky_clr) begin
                sticky_flags <= in_valid ? cap_flags : 5'b0;
            end else if (in_valid) begin
                sticky_flags <= sticky_flags | cap_flags;
            end

            if (drop) begin
                drop_err <= 1'b1;
            end else if (sticky_clr) begin
                drop_err <= 1'b0;
            end

            if (push && (result_cnt != '1)) begin
                result_cnt <= result_cnt + CNT_W'(1);
            end
        end
    end

endmodule
